// File: rtl/priority_encoder_if.sv
// Request/result bundle for the lowest-index-wins priority encoder.
// Signals: in (request vector), out/none (combinational result),
// out_q/none_q (result registered one cycle).
interface priority_encoder_if #(
    parameter int N = 4
);
    localparam int OUT_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     in;
    logic [OUT_W-1:0] out;
    logic             none;
    logic [OUT_W-1:0] out_q;
    logic             none_q;

    modport master (
        output in,
        input  out, none, out_q, none_q
    );

    modport slave (
        input  in,
        output out, none, out_q, none_q
    );
endinterface

// File: rtl/priority_encoder.sv
// Lowest-index-wins priority encoder with a registered result copy.
// Ports: CLK, Reset (sync, active-high), bus (slave: in -> out/none, out_q/none_q).
module priority_encoder #(
    parameter int N = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    priority_encoder_if.slave bus
);
    localparam int OUT_W = (N > 1) ? $clog2(N) : 1;

    logic [OUT_W-1:0] out_c;
    logic             none_c;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        out_c  = '0;
        none_c = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.in[i]) begin
                out_c  = OUT_W'(i);
                none_c = 1'b0;
            end
        end
    end

    assign bus.out  = out_c;
    assign bus.none = none_c;

    // Reset value encodes "no request".
    always_ff @(posedge CLK) begin
        if (Reset) begin
            bus.out_q  <= '0;
            bus.none_q <= 1'b1;
        end else begin
            bus.out_q  <= out_c;
            bus.none_q <= none_c;
        end
    end
endmodule

// File: tb/tb_priority_encoder.sv
// Directed-vector bench for priority_encoder at N = 8, 256, 5 and 1.
// A bench-side model is compared against every instance on each falling edge.
module tb_priority_encoder;
    logic CLK;
    logic Reset;

    int checks;
    int errors;

    priority_encoder_if #(8)   bus8   ();
    priority_encoder_if #(256) bus256 ();
    priority_encoder_if #(5)   bus5   ();
    priority_encoder_if #(1)   bus1   ();

    priority_encoder #(8) u8 (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus8.slave)
    );
    priority_encoder #(256) u256 (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus256.slave)
    );
    priority_encoder #(5) u5 (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus5.slave)
    );
    priority_encoder #(1) u1 (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus1.slave)
    );

    logic [256:0] wide_vec;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: index of lowest set bit among the first n bits, -1 if none.
    function automatic int lowest(logic [255:0] v, int n);
        for (int i = 0; i < n; i++) begin
            if (v[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    function automatic logic [255:0] get_in(int k);
        case (k)
            0: return 256'(bus8.in);
            1: return bus256.in;
            2: return 256'(bus5.in);
            default: return 256'(bus1.in);
        endcase
    endfunction

    function automatic int get_out(int k);
        case (k)
            0: return int'(bus8.out);
            1: return int'(bus256.out);
            2: return int'(bus5.out);
            default: return int'(bus1.out);
        endcase
    endfunction

    function automatic int get_none(int k);
        case (k)
            0: return int'(bus8.none);
            1: return int'(bus256.none);
            2: return int'(bus5.none);
            default: return int'(bus1.none);
        endcase
    endfunction

    function automatic int get_out_q(int k);
        case (k)
            0: return int'(bus8.out_q);
            1: return int'(bus256.out_q);
            2: return int'(bus5.out_q);
            default: return int'(bus1.out_q);
        endcase
    endfunction

    function automatic int get_none_q(int k);
        case (k)
            0: return int'(bus8.none_q);
            1: return int'(bus256.none_q);
            2: return int'(bus5.none_q);
            default: return int'(bus1.none_q);
        endcase
    endfunction

    int width_of [4] = '{8, 256, 5, 1};

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected registered values, updated by the model at each rising edge.
    int exp_oq [4];
    int exp_nq [4];
    bit q_valid = 1'b0;

    always @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = lowest(get_in(k), width_of[k]);
            if (Reset) begin
                exp_oq[k] <= 0;
                exp_nq[k] <= 1;
            end else begin
                exp_oq[k] <= (idx < 0) ? 0 : idx;
                exp_nq[k] <= (idx < 0) ? 1 : 0;
            end
        end
        if (Reset) q_valid <= 1'b1;
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = lowest(get_in(k), width_of[k]);
            chk($sformatf("model_out[N=%0d]", width_of[k]),
                get_out(k), (idx < 0) ? 0 : idx);
            chk($sformatf("model_none[N=%0d]", width_of[k]),
                get_none(k), (idx < 0) ? 1 : 0);
            if (q_valid) begin
                chk($sformatf("model_out_q[N=%0d]", width_of[k]),
                    get_out_q(k), exp_oq[k]);
                chk($sformatf("model_none_q[N=%0d]", width_of[k]),
                    get_none_q(k), exp_nq[k]);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        Reset      = 1'b1;
        bus8.in    = '0;
        bus256.in  = '0;
        bus5.in    = '0;
        bus1.in    = '0;
        wide_vec   = '0;

        tick();
        tick();
        #1;
        chk("reset_out_q", int'(bus8.out_q), 0);
        chk("reset_none_q", int'(bus8.none_q), 1);
        Reset = 1'b0;

        // All-zero request, one clock out of reset.
        tick();
        #1;
        chk("zero_none", int'(bus8.none), 1);
        chk("zero_out", int'(bus8.out), 0);
        chk("zero_none_q", int'(bus8.none_q), 1);
        chk("zero_out_q", int'(bus8.out_q), 0);

        // Walking one through N=8.
        for (int i = 0; i < 8; i++) begin
            tick();
            bus8.in = 8'(1 << i);
            #1;
            chk($sformatf("walk_out[%0d]", i), int'(bus8.out), i);
            chk($sformatf("walk_none[%0d]", i), int'(bus8.none), 0);
            if (i > 0) begin
                chk($sformatf("walk_out_q[%0d]", i), int'(bus8.out_q), i - 1);
            end else begin
                chk("walk_none_q[0]", int'(bus8.none_q), 1);
            end
        end

        // Multi-hot patterns.
        tick();
        bus8.in = 8'b1010_1000;
        #1;
        chk("multi_a8", int'(bus8.out), 3);
        tick();
        bus8.in = 8'b1111_1111;
        #1;
        chk("multi_ff", int'(bus8.out), 0);
        chk("multi_a8_q", int'(bus8.out_q), 3);
        tick();
        bus8.in = 8'b1000_0000;
        #1;
        chk("multi_80", int'(bus8.out), 7);
        chk("multi_ff_q", int'(bus8.out_q), 0);

        // Reset mid-stream: registered copy cleared, combinational unaffected.
        tick();
        bus8.in = 8'b0001_0000;
        Reset = 1'b1;
        #1;
        chk("rst_comb_out", int'(bus8.out), 4);
        tick();
        #1;
        chk("rst_out_q", int'(bus8.out_q), 0);
        chk("rst_none_q", int'(bus8.none_q), 1);
        chk("rst_comb_hold", int'(bus8.out), 4);
        Reset = 1'b0;
        tick();
        #1;
        chk("rel_out_q", int'(bus8.out_q), 4);
        chk("rel_none_q", int'(bus8.none_q), 0);

        // N=256 fed from a wider vector; bit 256 lies outside the encoder.
        tick();
        wide_vec = '0;
        wide_vec[256] = 1'b1;
        bus256.in = wide_vec[255:0];
        #1;
        chk("wide_none", int'(bus256.none), 1);
        chk("wide_zero_out", int'(bus256.out), 0);
        tick();
        wide_vec[200] = 1'b1;
        wide_vec[255] = 1'b1;
        bus256.in = wide_vec[255:0];
        #1;
        chk("wide_200", int'(bus256.out), 200);
        chk("wide_200_none", int'(bus256.none), 0);
        tick();
        wide_vec = '0;
        wide_vec[255] = 1'b1;
        bus256.in = wide_vec[255:0];
        #1;
        chk("wide_255", int'(bus256.out), 255);
        chk("wide_200_q", int'(bus256.out_q), 200);

        // N=5 exhaustive; model compare covers every pattern.
        for (int p = 0; p < 32; p++) begin
            tick();
            bus5.in = 5'(p);
        end
        tick();
        bus5.in = 5'b10100;
        #1;
        chk("n5_10100", int'(bus5.out), 2);
        tick();
        bus5.in = 5'b10000;
        #1;
        chk("n5_10000", int'(bus5.out), 4);
        tick();
        bus5.in = 5'b00000;
        #1;
        chk("n5_none", int'(bus5.none), 1);

        // N=1 exhaustive.
        tick();
        bus1.in = 1'b0;
        #1;
        chk("n1_zero_none", int'(bus1.none), 1);
        chk("n1_zero_out", int'(bus1.out), 0);
        tick();
        bus1.in = 1'b1;
        #1;
        chk("n1_one_none", int'(bus1.none), 0);
        chk("n1_one_out", int'(bus1.out), 0);
        tick();
        #1;
        chk("n1_one_none_q", int'(bus1.none_q), 0);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/priority_encoder.md
# priority_encoder

Parameterised lowest-index-wins priority encoder. Converts an N-bit one-hot or multi-hot request vector into the binary index of the lowest set bit, plus a "no bit set" flag. Primary consumer is the TCAM tag-match path, which uses the combinational outputs to produce `Hit_Index` and `h = ~none` in the same cycle as the lookup. A registered copy of the result is also provided for pipelined consumers, using the block's clock and reset.

## Interface
- `N`, default 4: request vector width; first (positional) parameter. Must be ≥ 1.
- Derived `OUT_W` = max(1, $clog2(N)): index width.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  input  1  clock; registered outputs update on rising edge.
- `Reset`  input  1  synchronous, active-high reset for registered outputs only.
- `in`  input  N  request vector; bit i set means entry i requests.
- `out`  output  OUT_W  combinational index of lowest set bit of `in`.
- `none`  output  1  combinational; 1 when `in` == 0.
- `out_q`  output  OUT_W  `out` registered one cycle.
- `none_q`  output  1  `none` registered one cycle.

## Operation
- Priority rule: the lowest index wins. `out` = smallest i with `in[i]`=1.
- Multiple bits set: only the lowest is reported. No error flag.
- `in` == 0: `none`=1 and `out`=0. The all-zero index is therefore ambiguous unless `none` is checked.
- `in[0]`=1: `out`=0 and `none`=0, whatever the other bits are.
- `out` and `none` are purely combinational in `in`. They do not depend on `CLK` or `Reset`, and there is no latch or state in that path.
- Connection width: a port vector wider than N connected to `in` is truncated to bits [N-1:0] by normal Verilog rules. Higher bits are ignored.
- N not a power of two: indices ≥ N are never produced.
- N = 1: `out` is 1 bit, constant 0; `none` = ~`in[0]`.
- Implementation is free: a loop scanning from high to low, or a tree. The result must be identical for every input pattern.

## Timing
- Combinational path: `in` → `out`/`none` settles within the same cycle, with zero-cycle latency.
- Registered path: at each rising `CLK` edge:
  - If `Reset`=1: `out_q` ← 0 and `none_q` ← 1.
  - Otherwise: `out_q` ← `out` and `none_q` ← `none`.
- Latency of the registered path is exactly 1 cycle.
- Reset values: `out_q`=0 and `none_q`=1 (encodes "no request"). The combinational outputs have no reset value and always track `in`.
- Reset asserted mid-stream: it takes effect at the next edge only. Combinational outputs are unaffected.
- Power-up before the first reset edge: `out_q`/`none_q` are X in simulation. Consumers must reset first.
- No handshake. `in` may change every cycle.

## Test plan
- N=8, `in`=8'b0000_0000 → `none`=1, `out`=0. After one clock with `Reset`=0: `none_q`=1, `out_q`=0.
- N=8, walk a single one through bits 0..7 → `out`=0..7 respectively, `none`=0. `out_q` equals the previous cycle's `out`.
- N=8, `in`=8'b1010_1000 → `out`=3. `in`=8'b1111_1111 → `out`=0. `in`=8'b1000_0000 → `out`=7.
- N=256 (TCAM size), driven through a 257-bit vector with bit 256 = X or 1 and bits 0..255 = 0 → `none`=1 (bit 256 ignored). Bit 200 and bit 255 set → `out`=200.
- N=5 and N=1 → exhaustive sweep of all input patterns, compared against a reference model. N=1: `in`=1 gives `out`=0, `none`=0; `in`=0 gives `none`=1.
- Reset check: `in`=8'b0001_0000 and `Reset`=1 for one edge → `out_q`=0, `none_q`=1 while `out`=4 combinationally. Deassert `Reset` → next edge `out_q`=4, `none_q`=0.
